// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard/forwarding scoreboard.
//   iss_class_t      - issue class of a decoded instruction
//   FWD_RF           - forwarding select meaning "read the register file"
//   forward_src*_t   - select encoding for the three-stage (EX/MEM/WB) core
//   ready_at_of()    - first tracker stage from which a class's result can be forwarded
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    ClsNone = 2'd0,
    ClsAlu  = 2'd1,
    ClsLoad = 2'd2,
    ClsMul  = 2'd3
  } iss_class_t;

  localparam int FWD_RF = 0;

  typedef enum logic [1:0] {
    FwdSrcaRf        = 2'd0,
    FwdSrcaAluOutDm  = 2'd1,
    FwdSrcaWrbckData = 2'd2
  } forward_srca_t;

  typedef enum logic [1:0] {
    FwdSrcbRf        = 2'd0,
    FwdSrcbAluOutDm  = 2'd1,
    FwdSrcbWrbckData = 2'd2
  } forward_srcb_t;

  // Loads produce data at the end of MEM, everything else at the end of EX.
  function automatic logic [1:0] ready_at_of(input iss_class_t cls);
    return (cls == ClsLoad) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> scoreboard bundle.
//   master : decode stage (drives id_*, flush; sees stall, selects, mul_busy)
//   slave  : hazard_scoreboard
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
);
  import hazard_scoreboard_pkg::*;

  localparam int FSEL_W = $clog2(DEPTH);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_wr;
  logic [REG_AW-1:0] id_dst;
  iss_class_t        id_class;
  logic              flush;

  logic              stall;
  logic [FSEL_W-1:0] fwd_a_sel;
  logic [FSEL_W-1:0] fwd_b_sel;
  logic              mul_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_dst, id_class, flush,
    input  stall, fwd_a_sel, fwd_b_sel, mul_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_dst, id_class, flush,
    output stall, fwd_a_sel, fwd_b_sel, mul_busy
  );

endinterface

// File: rtl/hazard_scoreboard_stage_tracker.sv
// DEPTH-entry tag shift register of in-flight register writes.
//   clk, rst_n     - clock, synchronous active-low reset
//   hold           - MUL occupies EX: stage 1 holds, stage 2 takes a bubble
//   push_valid     - accepted instruction writes a tracked register
//   push_dst       - its destination
//   push_ready_at  - first stage from which its result is forwardable
//   valid/dst/ready- per-stage state, index 1 = EX ... DEPTH = WB
module hazard_stage_tracker #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              push_valid,
  input  logic [REG_AW-1:0] push_dst,
  input  logic [1:0]        push_ready_at,
  output logic [DEPTH:1]    valid,
  output logic [REG_AW-1:0] dst [1:DEPTH],
  output logic [DEPTH:1]    ready
);

  logic [1:0] ready_at [1:DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its neighbour's pre-edge value and the shift is order-independent.
      if (!hold) valid[1] <= push_valid;
      valid[2] <= hold ? 1'b0 : valid[1];
      for (int k = 3; k <= DEPTH; k++) valid[k] <= valid[k-1];
    end
  end

  // NOTE: only the valid bits need reset; tag payloads are ignored while
  // invalid, so leaving them unreset keeps the array reset-free.
  always_ff @(posedge clk) begin
    if (!hold) begin
      dst[1]      <= push_dst;
      ready_at[1] <= push_ready_at;
    end
    for (int k = 2; k <= DEPTH; k++) begin
      dst[k]      <= dst[k-1];
      ready_at[k] <= ready_at[k-1];
    end
  end

  // A result in EX is not forwardable while the multiplier is still working.
  always_comb begin
    // NOTE: default first so no path through the block leaves ready unassigned
    // (which would infer a latch).
    ready = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      ready[k] = valid[k] && (k >= int'(ready_at[k])) && ((k != 1) || !hold);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller beside the ID/EX boundary.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - hazard_scoreboard_if.slave: decoded instruction in, stall,
//                registered forwarding selects and mul_busy out
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 3,
  parameter int MUL_LAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  bus
);

  localparam int FSEL_W = $clog2(DEPTH);
  localparam int MCW    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [MCW-1:0]    mul_cnt;
  logic              mul_hold;
  logic [DEPTH:1]    st_valid;
  logic [DEPTH:1]    st_ready;
  logic [REG_AW-1:0] st_dst [1:DEPTH];
  logic [FSEL_W-1:0] match_a, match_b;
  logic              hazard_a, hazard_b;
  logic              accept, push_valid;
  logic [FSEL_W-1:0] sel_a_q, sel_b_q;

  assign mul_hold = (mul_cnt != '0);

  hazard_stage_tracker #(.REG_AW(REG_AW), .DEPTH(DEPTH)) u_tracker (
    .clk           (clk),
    .rst_n         (rst_n),
    .hold          (mul_hold),
    .push_valid    (push_valid),
    .push_dst      (bus.id_dst),
    .push_ready_at (ready_at_of(bus.id_class)),
    .valid         (st_valid),
    .dst           (st_dst),
    .ready         (st_ready)
  );

  // Youngest valid producer among stages 1..DEPTH-1; WB is left to the
  // write-first register file. Scanning oldest-to-youngest lets the youngest win.
  function automatic logic [FSEL_W-1:0] find_match(input logic [REG_AW-1:0] src,
                                                    input logic used);
    logic [FSEL_W-1:0] sel;
    sel = FSEL_W'(FWD_RF);
    if (used && (src != '0)) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (st_valid[k] && (st_dst[k] == src)) sel = FSEL_W'(k);
      end
    end
    return sel;
  endfunction

  always_comb begin
    match_a  = find_match(bus.id_rs, bus.id_use_rs);
    match_b  = find_match(bus.id_rt, bus.id_use_rt);
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      if ((match_a == FSEL_W'(k)) && !st_ready[k]) hazard_a = 1'b1;
      if ((match_b == FSEL_W'(k)) && !st_ready[k]) hazard_b = 1'b1;
    end
  end

  assign bus.stall  = bus.id_valid && (hazard_a || hazard_b || mul_hold);
  assign accept     = bus.id_valid && !bus.stall && !bus.flush;
  assign push_valid = accept && bus.id_wr && (bus.id_dst != '0);

  // flush only affects the ID instruction; an in-flight MUL keeps counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_cnt <= '0;
      sel_a_q <= FSEL_W'(FWD_RF);
      sel_b_q <= FSEL_W'(FWD_RF);
    end else begin
      if (mul_hold)
        mul_cnt <= mul_cnt - MCW'(1);
      else if (accept && (bus.id_class == ClsMul))
        mul_cnt <= MCW'(MUL_LAT - 1);

      // Selects belong to the instruction sitting in EX, so they hold while MUL does.
      if (accept) begin
        sel_a_q <= match_a;
        sel_b_q <= match_b;
      end else if (!mul_hold) begin
        sel_a_q <= FSEL_W'(FWD_RF);
        sel_b_q <= FSEL_W'(FWD_RF);
      end
    end
  end

  assign bus.fwd_a_sel = sel_a_q;
  assign bus.fwd_b_sel = sel_b_q;
  assign bus.mul_busy  = mul_hold;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (REG_AW=5, DEPTH=3, MUL_LAT=4).
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(5), .DEPTH(3)) sb ();

  hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .MUL_LAT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sb)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
  } sel_exp_t;

  sel_exp_t exp_q[$];
  string    name_q[$];

  task automatic drive(input logic v, input logic fl, input logic [4:0] rs, input logic use_rs,
                       input logic [4:0] rt, input logic use_rt, input logic wr,
                       input logic [4:0] dst, input iss_class_t cls);
    sb.id_valid  = v;
    sb.flush     = fl;
    sb.id_rs     = rs;
    sb.id_use_rs = use_rs;
    sb.id_rt     = rt;
    sb.id_use_rt = use_rt;
    sb.id_wr     = wr;
    sb.id_dst    = dst;
    sb.id_class  = cls;
  endtask

  // One ID cycle: drive at negedge, check stall/mul_busy combinationally,
  // queue the selects expected in the following EX cycle and compare them
  // just after the rising edge.
  task automatic cycle(input string name, input logic v, input logic fl,
                       input logic [4:0] rs, input logic use_rs,
                       input logic [4:0] rt, input logic use_rt,
                       input logic wr, input logic [4:0] dst, input iss_class_t cls,
                       input logic exp_stall, input logic exp_busy,
                       input logic [1:0] exp_a, input logic [1:0] exp_b);
    sel_exp_t e;
    string    n;
    @(negedge clk);
    drive(v, fl, rs, use_rs, rt, use_rt, wr, dst, cls);
    #1;
    checks++;
    if (sb.stall !== exp_stall) begin
      errors++;
      $display("FAIL %s stall: got %b expected %b", name, sb.stall, exp_stall);
    end
    checks++;
    if (sb.mul_busy !== exp_busy) begin
      errors++;
      $display("FAIL %s mul_busy: got %b expected %b", name, sb.mul_busy, exp_busy);
    end
    exp_q.push_back('{a: exp_a, b: exp_b});
    name_q.push_back(name);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    checks++;
    if (sb.fwd_a_sel !== e.a) begin
      errors++;
      $display("FAIL %s fwd_a_sel: got %0d expected %0d", n, sb.fwd_a_sel, e.a);
    end
    checks++;
    if (sb.fwd_b_sel !== e.b) begin
      errors++;
      $display("FAIL %s fwd_b_sel: got %0d expected %0d", n, sb.fwd_b_sel, e.b);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle("idle", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, ClsNone, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (sb.stall !== 1'b0 || sb.mul_busy !== 1'b0 || sb.fwd_a_sel !== 2'd0 || sb.fwd_b_sel !== 2'd0) begin
      errors++;
      $display("FAIL %s: got stall=%b busy=%b a=%0d b=%0d expected all 0",
               name, sb.stall, sb.mul_busy, sb.fwd_a_sel, sb.fwd_b_sel);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd3, ClsMul);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, ClsNone);
  endtask

  task automatic test_alu_chain();
    idle(3);
    cycle("alu_p0",  1, 0, 5'd1, 1, 5'd2, 1, 1, 5'd3, ClsAlu, 0, 0, 2'd0, 2'd0);
    cycle("alu_d1",  1, 0, 5'd3, 1, 5'd0, 0, 1, 5'd8, ClsAlu, 0, 0, 2'd1, 2'd0);
    idle(3);
    cycle("alu_p0",  1, 0, 5'd1, 1, 5'd2, 1, 1, 5'd3, ClsAlu, 0, 0, 2'd0, 2'd0);
    cycle("alu_u1",  1, 0, 5'd1, 1, 5'd2, 1, 1, 5'd9, ClsAlu, 0, 0, 2'd0, 2'd0);
    cycle("alu_d2",  1, 0, 5'd3, 1, 5'd9, 1, 0, 5'd0, ClsAlu, 0, 0, 2'd2, 2'd1);
    idle(3);
    cycle("alu_p0",  1, 0, 5'd1, 1, 5'd2, 1, 1, 5'd3, ClsAlu, 0, 0, 2'd0, 2'd0);
    cycle("alu_u1",  1, 0, 5'd1, 1, 5'd2, 1, 0, 5'd0, ClsAlu, 0, 0, 2'd0, 2'd0);
    cycle("alu_u2",  1, 0, 5'd1, 1, 5'd2, 1, 0, 5'd0, ClsAlu, 0, 0, 2'd0, 2'd0);
    cycle("alu_d3",  1, 0, 5'd3, 1, 5'd3, 1, 0, 5'd0, ClsAlu, 0, 0, 2'd0, 2'd0);
  endtask

  task automatic test_load_use();
    idle(3);
    cycle("lw4",     1, 0, 5'd1, 1, 5'd0, 0, 1, 5'd4, ClsLoad, 0, 0, 2'd0, 2'd0);
    cycle("lu_stall",1, 0, 5'd2, 1, 5'd4, 1, 1, 5'd10, ClsAlu, 1, 0, 2'd0, 2'd0);
    cycle("lu_go",   1, 0, 5'd2, 1, 5'd4, 1, 1, 5'd10, ClsAlu, 0, 0, 2'd0, 2'd2);
  endtask

  task automatic test_mul();
    idle(3);
    cycle("mul_pre", 1, 0, 5'd1, 1, 5'd0, 0, 1, 5'd6, ClsAlu, 0, 0, 2'd0, 2'd0);
    cycle("mul5",    1, 0, 5'd6, 1, 5'd2, 1, 1, 5'd5, ClsMul, 0, 0, 2'd1, 2'd0);
    for (int i = 0; i < 3; i++)
      cycle("mul_hold", 1, 0, 5'd5, 1, 5'd0, 0, 1, 5'd11, ClsAlu, 1, 1, 2'd1, 2'd0);
    cycle("mul_dep", 1, 0, 5'd5, 1, 5'd0, 0, 1, 5'd11, ClsAlu, 0, 0, 2'd1, 2'd0);
    idle(1);
  endtask

  task automatic test_zero_reg();
    idle(3);
    cycle("lw0",     1, 0, 5'd1, 1, 5'd0, 0, 1, 5'd0, ClsLoad, 0, 0, 2'd0, 2'd0);
    cycle("rd0",     1, 0, 5'd0, 1, 5'd0, 1, 1, 5'd12, ClsAlu, 0, 0, 2'd0, 2'd0);
  endtask

  task automatic test_flush_stall();
    idle(3);
    cycle("fl_lw4",  1, 0, 5'd1, 1, 5'd0, 0, 1, 5'd4, ClsLoad, 0, 0, 2'd0, 2'd0);
    cycle("fl_kill", 1, 1, 5'd2, 1, 5'd4, 1, 1, 5'd6, ClsAlu, 1, 0, 2'd0, 2'd0);
    cycle("fl_rd6",  1, 0, 5'd6, 1, 5'd0, 0, 0, 5'd0, ClsAlu, 0, 0, 2'd0, 2'd0);
  endtask

  task automatic test_flush_mul();
    idle(3);
    cycle("flm_mul", 1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd7, ClsMul, 0, 0, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++)
      cycle("flm_hold", 1, 1, 5'd7, 1, 5'd0, 0, 1, 5'd13, ClsAlu, 1, 1, 2'd0, 2'd0);
    cycle("flm_dep", 1, 0, 5'd7, 1, 5'd0, 0, 1, 5'd13, ClsAlu, 0, 0, 2'd1, 2'd0);
    idle(1);
  endtask

  task automatic test_reset_mid();
    idle(3);
    cycle("rm_mul",  1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd5, ClsMul, 0, 0, 2'd0, 2'd0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, ClsNone);
    @(posedge clk);
    #1;
    check_quiet("reset_mid");
    rst_n = 1'b1;
    cycle("rm_dep",  1, 0, 5'd5, 1, 5'd0, 0, 0, 5'd0, ClsAlu, 0, 0, 2'd0, 2'd0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, ClsNone);
    test_reset();
    test_alu_chain();
    test_load_use();
    test_mul();
    test_zero_reg();
    test_flush_stall();
    test_flush_mul();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
